branch_resolve_bht: RTL and testbench

- Next-generation ID-stage branch resolver for the 5-stage MIPS pipeline.
- Decodes all conditional branches: beq, bne, blez, bgtz, bltz, bgez, bltzal, bgezal.
- Evaluates the branch condition on forwarded operands and flags misprediction against a prediction made in IF.
- Prediction comes from an internal table of 2-bit saturating counters, trained at resolution; performance counters are included.

---
 rtl/branch_resolve_bht_pkg.sv | 30 +++
 rtl/branch_resolve_bht_if.sv | 34 +++
 rtl/branch_resolve_bht_cond.sv | 46 ++++
 rtl/branch_resolve_bht.sv | 74 +++++++
 tb/tb_branch_resolve_bht.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_bht_pkg.sv
// Shared MIPS branch definitions: opcode and REGIMM rt encodings plus the
// 2-bit saturating counter states and their update rule.
package mips_defs;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Saturating step: taken moves toward ST, not-taken toward SNT.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != ST) nxt = cnt + 2'd1;
    else if (!taken && cnt != SNT) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_if.sv
// IF/ID branch-resolution bundle. No handshake: every signal is valid each
// cycle, and stall_d alone gates state updates.
interface bht_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic [31:0]      pc_f;
  logic             pred_taken_f;
  logic [31:0]      instr_d;
  logic [31:0]      pc_d;
  logic [WIDTH-1:0] mfrsd;
  logic [WIDTH-1:0] mfrtd;
  logic             stall_d;
  logic             flush_d;
  logic             cmp_true;
  logic             is_branch_d;
  logic             link_d;
  logic             pred_d;
  logic             mispredict_d;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport slave (
    input  pc_f, instr_d, pc_d, mfrsd, mfrtd, stall_d, flush_d,
    output pred_taken_f, cmp_true, is_branch_d, link_d, pred_d,
           mispredict_d, br_cnt, miss_cnt
  );

  modport master (
    output pc_f, instr_d, pc_d, mfrsd, mfrtd, stall_d, flush_d,
    input  pred_taken_f, cmp_true, is_branch_d, link_d, pred_d,
           mispredict_d, br_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_resolve_bht_cond.sv
// Combinational decode and signed condition evaluation for MIPS conditional
// branches; unknown encodings report not-a-branch and not-taken.
module branch_cond
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       op_i,
  input  logic [4:0]       rt_sel_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rt_val_i,
  output logic             cmp_true_o,
  output logic             is_branch_o,
  output logic             link_o
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs_val_i[WIDTH-1];
  assign rs_zero = (rs_val_i == '0);

  always_comb begin
    cmp_true_o  = 1'b0;
    is_branch_o = 1'b0;
    link_o      = 1'b0;
    case (op_i)
      OP_BEQ:  begin is_branch_o = 1'b1; cmp_true_o = (rs_val_i == rt_val_i); end
      OP_BNE:  begin is_branch_o = 1'b1; cmp_true_o = (rs_val_i != rt_val_i); end
      OP_BLEZ: begin is_branch_o = 1'b1; cmp_true_o = rs_neg | rs_zero; end
      OP_BGTZ: begin is_branch_o = 1'b1; cmp_true_o = ~rs_neg & ~rs_zero; end
      OP_REGIMM: begin
        // The rt field selects the condition; bit 4 marks the linking forms.
        case (rt_sel_i)
          RT_BLTZ:   begin is_branch_o = 1'b1; cmp_true_o = rs_neg; end
          RT_BGEZ:   begin is_branch_o = 1'b1; cmp_true_o = ~rs_neg; end
          RT_BLTZAL: begin is_branch_o = 1'b1; cmp_true_o = rs_neg; link_o = 1'b1; end
          RT_BGEZAL: begin is_branch_o = 1'b1; cmp_true_o = ~rs_neg; link_o = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// ID-stage branch resolver with a 2-bit-counter branch history table,
// a prediction register carried from IF, and resolve/miss counters.
module branch_resolve_bht
  import mips_defs::*;
#(
  parameter int WIDTH   = 32,
  parameter int BHT_IDX = 4,
  parameter int CNT_W   = 32
) (
  input logic  clk,
  input logic  reset,
  bht_if.slave bus
);

  localparam int DEPTH = 2 ** BHT_IDX;

  logic [1:0]         bht_q [DEPTH];
  logic               pred_q;
  logic               pred_d;
  logic [CNT_W-1:0]   br_cnt_q;
  logic [CNT_W-1:0]   miss_cnt_q;
  logic [BHT_IDX-1:0] rd_idx;
  logic [BHT_IDX-1:0] wr_idx;
  logic [1:0]         upd_d;
  logic               cmp_true;
  logic               is_branch;
  logic               link;
  logic               mispredict;
  logic               resolve;

  branch_cond #(.WIDTH(WIDTH)) u_cond (
    .op_i        (bus.instr_d[31:26]),
    .rt_sel_i    (bus.instr_d[20:16]),
    .rs_val_i    (bus.mfrsd),
    .rt_val_i    (bus.mfrtd),
    .cmp_true_o  (cmp_true),
    .is_branch_o (is_branch),
    .link_o      (link)
  );

  assign rd_idx     = bus.pc_f[BHT_IDX+1:2];
  assign wr_idx     = bus.pc_d[BHT_IDX+1:2];
  assign resolve    = is_branch & ~bus.stall_d;
  assign mispredict = resolve & (pred_q != cmp_true);
  assign upd_d      = sat_update(bht_q[wr_idx], cmp_true);
  assign pred_d     = bus.flush_d ? 1'b0 : bus.pred_taken_f;

  // Table read sees the pre-update value; a same-cycle write lands at the edge.
  assign bus.pred_taken_f = bht_q[rd_idx][1];
  assign bus.cmp_true     = cmp_true;
  assign bus.is_branch_d  = is_branch;
  assign bus.link_d       = link;
  assign bus.pred_d       = pred_q;
  assign bus.mispredict_d = mispredict;
  assign bus.br_cnt       = br_cnt_q;
  assign bus.miss_cnt     = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= WNT;
      pred_q     <= 1'b0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (!bus.stall_d) begin
      pred_q <= pred_d;
      if (resolve) begin
        bht_q[wr_idx] <= upd_d;
        br_cnt_q      <= br_cnt_q + 1'b1;
        if (mispredict) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: a decode/compare vector table plus
// hand-sequenced training, stall, flush, reset and counter-wrap scenarios.
module tb_branch_resolve_bht;
  import mips_defs::*;

  localparam int WIDTH   = 32;
  localparam int BHT_IDX = 4;
  localparam int CNT_W   = 4;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bht_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_if ();

  branch_resolve_bht #(.WIDTH(WIDTH), .BHT_IDX(BHT_IDX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd1, rt, 16'h0010};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_cmp;
    logic        exp_br;
    logic        exp_link;
  } vec_t;

  vec_t        vecs[13];
  logic [1:0]  nt_exp[5];

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{"beq_eq",     mk_instr(OP_BEQ,    5'd2),      32'd5,        32'd5, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{"bne_eq",     mk_instr(OP_BNE,    5'd2),      32'd5,        32'd5, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{"beq_ne",     mk_instr(OP_BEQ,    5'd2),      32'd5,        32'd6, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"blez_zero",  mk_instr(OP_BLEZ,   5'd0),      32'd0,        32'd9, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{"blez_neg",   mk_instr(OP_BLEZ,   5'd0),      32'hFFFFFFFF, 32'd0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{"bgtz_zero",  mk_instr(OP_BGTZ,   5'd0),      32'd0,        32'd0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{"bgtz_pos",   mk_instr(OP_BGTZ,   5'd0),      32'd7,        32'd0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{"bgez_min",   mk_instr(OP_REGIMM, RT_BGEZ),   32'h80000000, 32'd0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"bltz_min",   mk_instr(OP_REGIMM, RT_BLTZ),   32'h80000000, 32'd0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{"bltzal_neg", mk_instr(OP_REGIMM, RT_BLTZAL), 32'hFFFFFFFF, 32'd0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{"bgezal_neg", mk_instr(OP_REGIMM, RT_BGEZAL), 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{"undef_zero", 32'h00000000,                   32'd0,        32'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"regimm_bad", mk_instr(OP_REGIMM, 5'b00010),  32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0};
    nt_exp   = '{WT, WNT, SNT, SNT, SNT};

    // ---- reset ----
    reset          = 1'b1;
    bus_if.pc_f    = 32'h3000;
    bus_if.instr_d = 32'h0;
    bus_if.pc_d    = 32'h3000;
    bus_if.mfrsd   = '0;
    bus_if.mfrtd   = '0;
    bus_if.stall_d = 1'b0;
    bus_if.flush_d = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    settle();
    check("rst_pred_taken_f", 32'(bus_if.pred_taken_f), 32'd0);
    check("rst_pred_d",       32'(bus_if.pred_d),       32'd0);
    check("rst_br_cnt",       32'(bus_if.br_cnt),       32'd0);
    check("rst_miss_cnt",     32'(bus_if.miss_cnt),     32'd0);
    for (int i = 0; i < 2 ** BHT_IDX; i++)
      check($sformatf("rst_entry%0d", i), 32'(dut.bht_q[i]), 32'(WNT));

    // ---- decode/compare table (stalled, so no state moves) ----
    bus_if.stall_d = 1'b1;
    for (int v = 0; v < 13; v++) begin
      bus_if.instr_d = vecs[v].instr;
      bus_if.mfrsd   = vecs[v].rs;
      bus_if.mfrtd   = vecs[v].rt;
      settle();
      check({vecs[v].name, "_cmp"},  32'(bus_if.cmp_true),     32'(vecs[v].exp_cmp));
      check({vecs[v].name, "_br"},   32'(bus_if.is_branch_d),  32'(vecs[v].exp_br));
      check({vecs[v].name, "_link"}, 32'(bus_if.link_d),       32'(vecs[v].exp_link));
      check({vecs[v].name, "_mis"},  32'(bus_if.mispredict_d), 32'd0);
    end
    tick();
    check("vec_br_cnt_held", 32'(bus_if.br_cnt), 32'd0);

    // ---- training: taken beq at 0x3004 ----
    bus_if.stall_d = 1'b0;
    bus_if.pc_d    = 32'h3004;
    bus_if.pc_f    = 32'h3004;
    bus_if.instr_d = mk_instr(OP_BEQ, 5'd2);
    bus_if.mfrsd   = 32'd5;
    bus_if.mfrtd   = 32'd5;
    settle();
    check("tr1_alias_old",  32'(bus_if.pred_taken_f), 32'd0);
    check("tr1_mispredict", 32'(bus_if.mispredict_d), 32'd1);
    tick();
    check("tr1_entry",      32'(dut.bht_q[1]),        32'(WT));
    check("tr1_br_cnt",     32'(bus_if.br_cnt),       32'd1);
    check("tr1_miss_cnt",   32'(bus_if.miss_cnt),     32'd1);
    check("tr1_pred_d",     32'(bus_if.pred_d),       32'd0);
    check("tr1_lookup_new", 32'(bus_if.pred_taken_f), 32'd1);

    bus_if.instr_d = 32'h0;
    settle();
    check("gap_mispredict", 32'(bus_if.mispredict_d), 32'd0);
    tick();
    check("gap_pred_d", 32'(bus_if.pred_d), 32'd1);
    check("gap_br_cnt", 32'(bus_if.br_cnt), 32'd1);

    bus_if.instr_d = mk_instr(OP_BEQ, 5'd2);
    settle();
    check("tr2_mispredict", 32'(bus_if.mispredict_d), 32'd0);
    tick();
    check("tr2_entry",    32'(dut.bht_q[1]),    32'(ST));
    check("tr2_br_cnt",   32'(bus_if.br_cnt),   32'd2);
    check("tr2_miss_cnt", 32'(bus_if.miss_cnt), 32'd1);
    check("tr2_pred_d",   32'(bus_if.pred_d),   32'd1);

    // ---- bgezal not taken while predicted taken ----
    bus_if.pc_d    = 32'h3008;
    bus_if.instr_d = mk_instr(OP_REGIMM, RT_BGEZAL);
    bus_if.mfrsd   = 32'hFFFFFFFF;
    settle();
    check("bgezal_cmp",  32'(bus_if.cmp_true),     32'd0);
    check("bgezal_link", 32'(bus_if.link_d),       32'd1);
    check("bgezal_mis",  32'(bus_if.mispredict_d), 32'd1);
    tick();
    check("bgezal_entry",    32'(dut.bht_q[2]),    32'(SNT));
    check("bgezal_br_cnt",   32'(bus_if.br_cnt),   32'd3);
    check("bgezal_miss_cnt", 32'(bus_if.miss_cnt), 32'd2);
    check("bgezal_pred_d",   32'(bus_if.pred_d),   32'd1);

    // ---- five not-taken resolves at 0x3004 ----
    bus_if.pc_d    = 32'h3004;
    bus_if.pc_f    = 32'h3000;
    bus_if.instr_d = mk_instr(OP_BEQ, 5'd2);
    bus_if.mfrsd   = 32'd5;
    bus_if.mfrtd   = 32'd6;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("nt%0d_mis", k), 32'(bus_if.mispredict_d), (k == 0) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("nt%0d_entry", k), 32'(dut.bht_q[1]),    32'(nt_exp[k]));
      check($sformatf("nt%0d_br", k),    32'(bus_if.br_cnt),   32'(4 + k));
      check($sformatf("nt%0d_miss", k),  32'(bus_if.miss_cnt), 32'd3);
    end

    // ---- stall with a taken branch in ID ----
    bus_if.pc_f    = 32'h3004;
    bus_if.mfrtd   = 32'd5;
    bus_if.stall_d = 1'b1;
    for (int s = 0; s < 3; s++) begin
      settle();
      check($sformatf("st%0d_cmp", s), 32'(bus_if.cmp_true),     32'd1);
      check($sformatf("st%0d_mis", s), 32'(bus_if.mispredict_d), 32'd0);
      tick();
      check($sformatf("st%0d_entry", s), 32'(dut.bht_q[1]),    32'(SNT));
      check($sformatf("st%0d_br", s),    32'(bus_if.br_cnt),   32'd8);
      check($sformatf("st%0d_miss", s),  32'(bus_if.miss_cnt), 32'd3);
      check($sformatf("st%0d_pred", s),  32'(bus_if.pred_d),   32'd0);
    end
    bus_if.stall_d = 1'b0;
    settle();
    check("rel_mis", 32'(bus_if.mispredict_d), 32'd1);
    tick();
    check("rel_entry", 32'(dut.bht_q[1]),    32'(WNT));
    check("rel_br",    32'(bus_if.br_cnt),   32'd9);
    check("rel_miss",  32'(bus_if.miss_cnt), 32'd4);
    tick();
    check("tk_entry", 32'(dut.bht_q[1]),    32'(WT));
    check("tk_br",    32'(bus_if.br_cnt),   32'd10);
    check("tk_miss",  32'(bus_if.miss_cnt), 32'd5);

    // ---- flush clears pred_d ----
    bus_if.instr_d = 32'h0;
    tick();
    check("pre_flush_pred", 32'(bus_if.pred_d), 32'd1);
    bus_if.flush_d = 1'b1;
    tick();
    check("flush_pred", 32'(bus_if.pred_d), 32'd0);
    bus_if.flush_d = 1'b0;

    // ---- train to ST, then reset mid-operation ----
    bus_if.instr_d = mk_instr(OP_BEQ, 5'd2);
    tick();
    check("st_entry", 32'(dut.bht_q[1]),    32'(ST));
    check("st_br",    32'(bus_if.br_cnt),   32'd11);
    check("st_miss",  32'(bus_if.miss_cnt), 32'd6);
    check("st_pred",  32'(bus_if.pred_d),   32'd1);
    reset = 1'b1;
    settle();
    check("rst2_cmp_live",  32'(bus_if.cmp_true),     32'd1);
    check("rst2_pred_live", 32'(bus_if.pred_taken_f), 32'd1);
    tick();
    check("rst2_entry",   32'(dut.bht_q[1]),        32'(WNT));
    check("rst2_entry2",  32'(dut.bht_q[2]),        32'(WNT));
    check("rst2_br",      32'(bus_if.br_cnt),       32'd0);
    check("rst2_miss",    32'(bus_if.miss_cnt),     32'd0);
    check("rst2_pred_d",  32'(bus_if.pred_d),       32'd0);
    check("rst2_pred_f",  32'(bus_if.pred_taken_f), 32'd0);
    reset = 1'b0;

    // ---- counter wrap (CNT_W = 4) ----
    bus_if.pc_d = 32'h300C;
    bus_if.pc_f = 32'h3000;
    repeat (15) tick();
    check("wrap_br_max",   32'(bus_if.br_cnt),   32'd15);
    check("wrap_miss_max", 32'(bus_if.miss_cnt), 32'd15);
    tick();
    check("wrap_br_zero",   32'(bus_if.br_cnt),   32'd0);
    check("wrap_miss_zero", 32'(bus_if.miss_cnt), 32'd0);
    check("wrap_entry_sat", 32'(dut.bht_q[3]),    32'(ST));

    // ---- report ----
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
